// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with combinational strobes.
// Optional performance counters enabled by defining MC_CTRL_PERF_CNT_EN.
module mc_ctrl #(
  parameter int ALUOP_W = 4,
  parameter int NPCOP_W = 2,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         Op,
  input  logic [5:0]         Funct,
  input  logic               Zero,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               EXTOp,
  output logic               ALUSrc,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [NPCOP_W-1:0] NPCOp,
  output logic [1:0]         GPRSel,
  output logic [1:0]         WDSel,
  output logic               illegal,
  output logic [2:0]         state
`ifdef MC_CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   instr_cnt
`endif
);

  if (ALUOP_W < 4 || NPCOP_W < 2 || CNT_W < 1) begin : g_bad_cfg
    $error("mc_ctrl: ALUOP_W >= 4, NPCOP_W >= 2 and CNT_W >= 1 required");
  end

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [4:0] {
    K_ADD, K_ADDU, K_SUB, K_SUBU, K_AND, K_OR, K_NOR, K_SLT, K_SLTU, K_SLL,
    K_ADDI, K_ANDI, K_ORI, K_SLTI, K_LUI, K_LW, K_SW, K_BEQ, K_BNE,
    K_J, K_JAL, K_ILL
  } kind_t;

  localparam logic [ALUOP_W-1:0] ALU_NOP  = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] ALU_SLT  = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] ALU_SLTU = ALUOP_W'(6);
  localparam logic [ALUOP_W-1:0] ALU_SLL  = ALUOP_W'(7);
  localparam logic [ALUOP_W-1:0] ALU_LUI  = ALUOP_W'(8);
  localparam logic [ALUOP_W-1:0] ALU_NOR  = ALUOP_W'(9);

  localparam logic [NPCOP_W-1:0] NPC_PLUS4  = NPCOP_W'(0);
  localparam logic [NPCOP_W-1:0] NPC_BRANCH = NPCOP_W'(1);
  localparam logic [NPCOP_W-1:0] NPC_JUMP   = NPCOP_W'(2);

  localparam logic [1:0] GPR_RD = 2'd0;
  localparam logic [1:0] GPR_RT = 2'd1;
  localparam logic [1:0] GPR_31 = 2'd2;
  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MEM = 2'd1;
  localparam logic [1:0] WD_PC  = 2'd2;

  state_t               r_state;
  state_t               w_next;
  kind_t                w_kind;
  logic [ALUOP_W-1:0]   w_alu_op;
  logic                 w_alu_src;
  logic                 w_ext_op;
  logic                 w_taken;

  always_comb begin
    w_kind = K_ILL;
    case (Op)
      6'h00: begin
        case (Funct)
          6'h00:   w_kind = K_SLL;
          6'h20:   w_kind = K_ADD;
          6'h21:   w_kind = K_ADDU;
          6'h22:   w_kind = K_SUB;
          6'h23:   w_kind = K_SUBU;
          6'h24:   w_kind = K_AND;
          6'h25:   w_kind = K_OR;
          6'h27:   w_kind = K_NOR;
          6'h2A:   w_kind = K_SLT;
          6'h2B:   w_kind = K_SLTU;
          default: w_kind = K_ILL;
        endcase
      end
      6'h02:   w_kind = K_J;
      6'h03:   w_kind = K_JAL;
      6'h04:   w_kind = K_BEQ;
      6'h05:   w_kind = K_BNE;
      6'h08:   w_kind = K_ADDI;
      6'h0A:   w_kind = K_SLTI;
      6'h0C:   w_kind = K_ANDI;
      6'h0D:   w_kind = K_ORI;
      6'h0F:   w_kind = K_LUI;
      6'h23:   w_kind = K_LW;
      6'h2B:   w_kind = K_SW;
      default: w_kind = K_ILL;
    endcase
  end

  always_comb begin
    w_alu_op  = ALU_NOP;
    w_alu_src = 1'b0;
    w_ext_op  = 1'b0;
    case (w_kind)
      K_ADD, K_ADDU:  w_alu_op = ALU_ADD;
      K_SUB, K_SUBU:  w_alu_op = ALU_SUB;
      K_AND:          w_alu_op = ALU_AND;
      K_OR:           w_alu_op = ALU_OR;
      K_NOR:          w_alu_op = ALU_NOR;
      K_SLT:          w_alu_op = ALU_SLT;
      K_SLTU:         w_alu_op = ALU_SLTU;
      K_SLL:          w_alu_op = ALU_SLL;
      K_ADDI, K_LW, K_SW: begin
        w_alu_op  = ALU_ADD;
        w_alu_src = 1'b1;
        w_ext_op  = 1'b1;
      end
      K_ANDI: begin
        w_alu_op  = ALU_AND;
        w_alu_src = 1'b1;
        w_ext_op  = 1'b1;
      end
      K_SLTI: begin
        w_alu_op  = ALU_SLT;
        w_alu_src = 1'b1;
        w_ext_op  = 1'b1;
      end
      K_ORI: begin
        w_alu_op  = ALU_OR;
        w_alu_src = 1'b1;
      end
      K_LUI: begin
        w_alu_op  = ALU_LUI;
        w_alu_src = 1'b1;
      end
      K_BEQ, K_BNE: begin
        w_alu_op = ALU_SUB;
        w_ext_op = 1'b1;
      end
      default: w_alu_op = ALU_NOP;
    endcase
  end

  assign w_taken = ((w_kind == K_BEQ) && Zero) || ((w_kind == K_BNE) && !Zero);

  always_comb begin
    w_next   = S_FETCH;
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    illegal  = 1'b0;
    EXTOp    = 1'b0;
    ALUSrc   = 1'b0;
    ALUOp    = ALU_NOP;
    NPCOp    = NPC_PLUS4;
    GPRSel   = GPR_RD;
    WDSel    = WD_ALU;
    case (r_state)
      S_FETCH: begin
        MemRead = 1'b1;
        NPCOp   = NPC_PLUS4;
        if (mem_ready) begin
          PCWrite = 1'b1;
          IRWrite = 1'b1;
          w_next  = S_DECODE;
        end else begin
          w_next  = S_FETCH;
        end
      end
      S_DECODE: begin
        case (w_kind)
          K_J: begin
            PCWrite = 1'b1;
            NPCOp   = NPC_JUMP;
            w_next  = S_FETCH;
          end
          K_JAL: begin
            PCWrite  = 1'b1;
            NPCOp    = NPC_JUMP;
            RegWrite = 1'b1;
            GPRSel   = GPR_31;
            WDSel    = WD_PC;
            w_next   = S_FETCH;
          end
          K_ILL: begin
            illegal = 1'b1;
            w_next  = S_FETCH;
          end
          default: w_next = S_EXEC;
        endcase
      end
      S_EXEC: begin
        EXTOp  = w_ext_op;
        ALUSrc = w_alu_src;
        ALUOp  = w_alu_op;
        if (w_taken) begin
          PCWrite = 1'b1;
          NPCOp   = NPC_BRANCH;
        end
        case (w_kind)
          K_BEQ, K_BNE, K_J, K_JAL, K_ILL: w_next = S_FETCH;
          K_LW, K_SW:                      w_next = S_MEM;
          default:                         w_next = S_WB;
        endcase
      end
      S_MEM: begin
        EXTOp    = w_ext_op;
        ALUSrc   = w_alu_src;
        ALUOp    = w_alu_op;
        MemRead  = (w_kind == K_LW);
        MemWrite = (w_kind == K_SW);
        if (w_kind != K_LW && w_kind != K_SW) begin
          w_next = S_FETCH;
        end else if (mem_ready) begin
          w_next = (w_kind == K_LW) ? S_WB : S_FETCH;
        end else begin
          w_next = S_MEM;
        end
      end
      S_WB: begin
        EXTOp    = w_ext_op;
        ALUSrc   = w_alu_src;
        ALUOp    = w_alu_op;
        RegWrite = 1'b1;
        GPRSel   = (Op == 6'h00) ? GPR_RD : GPR_RT;
        WDSel    = (w_kind == K_LW) ? WD_MEM : WD_ALU;
        w_next   = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
    // State is already FETCH during reset, so its read request must be masked explicitly.
    if (rst) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      illegal  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  assign state = r_state;

`ifdef MC_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_instr_cnt;
  logic             w_retire;

  assign w_retire = (r_state == S_DECODE || r_state == S_EXEC ||
                     r_state == S_MEM    || r_state == S_WB) && (w_next == S_FETCH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cycle_cnt <= '0;
      r_instr_cnt <= '0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
      if (w_retire) begin
        r_instr_cnt <= r_instr_cnt + CNT_W'(1);
      end
    end
  end

  assign cycle_cnt = r_cycle_cnt;
  assign instr_cnt = r_instr_cnt;
`endif

endmodule
